mgmt_counter_timer: RTL and testbench

//  32-bit programmable counter/timer peripheral on the management SoC register bus.
//  The CPU loads a limit, selects the count direction and mode, then polls the count or takes an interrupt.

---
 rtl/mgmt_timer_pkg.sv | 31 +++
 rtl/timer_prescaler.sv | 31 +++
 rtl/mgmt_counter_timer.sv | 120 ++++++++++++
 tb/tb_mgmt_counter_timer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mgmt_timer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mgmt_timer_pkg : config bit map and byte-lane merge helper          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mgmt_timer_pkg;

  localparam int REG_W         = 32;
  localparam int CFG_EN        = 0;
  localparam int CFG_ONESHOT   = 1;
  localparam int CFG_UP        = 2;
  localparam int CFG_IRQEN     = 3;
  localparam int CFG_PEND      = 5;
  localparam int CFG_PRESC_LSB = 8;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [REG_W-1:0] bytewrite(
    input logic [REG_W-1:0]   old_data,
    input logic [REG_W-1:0]   wdata,
    input logic [REG_W/8-1:0] we
  );
    logic [REG_W-1:0] w_merged;
    w_merged = old_data;
    for (int b = 0; b < REG_W/8; b++) begin
      if (we[b]) w_merged[8*b +: 8] = wdata[8*b +: 8];
    end
    return w_merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | timer_prescaler : emits a tick every (i_div+1) enabled clk cycles   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic [PRESCALE_W-1:0] i_div,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_pcnt;

  assign o_tick = i_en & (r_pcnt == i_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if (i_en && !o_tick) begin
      r_pcnt <= r_pcnt + 1'b1;
    end else begin
      r_pcnt <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mgmt_counter_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mgmt_counter_timer : programmable up/down counter-timer with IRQ    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mgmt_counter_timer
  import mgmt_timer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       reg_cfg_we,
  input  logic [31:0]      reg_cfg_di,
  output logic [31:0]      reg_cfg_do,
  input  logic [3:0]       reg_val_we,
  input  logic [WIDTH-1:0] reg_val_di,
  output logic [WIDTH-1:0] reg_val_do,
  input  logic [3:0]       reg_dat_we,
  input  logic [WIDTH-1:0] reg_dat_di,
  output logic [WIDTH-1:0] reg_dat_do,
  output logic             tick_out,
  output logic             irq_out
);

  logic                  r_en;
  logic                  r_oneshot;
  logic                  r_up;
  logic                  r_irqen;
  logic                  r_pend;
  logic [PRESCALE_W-1:0] r_presc;
  logic [WIDTH-1:0]      r_value;
  logic [WIDTH-1:0]      r_limit;
  logic                  r_tick;

  logic                  w_tick;
  logic                  w_val_wr;
  logic                  w_at_term;
  logic                  w_term;
  logic                  w_w1c;
  logic [WIDTH-1:0]      w_value_nxt;
  logic                  w_unused;

  assign w_unused = ^{reg_cfg_di[31:16], reg_cfg_di[7:6], reg_cfg_di[4], reg_cfg_we[3:2]};

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_presc (
    .clk    (clk),
    .rst    (reset),
    .i_en   (r_en),
    .i_div  (r_presc),
    .o_tick (w_tick)
  );

  assign w_val_wr  = |reg_val_we;
  assign w_at_term = r_up ? (r_value == r_limit) : (r_value == '0);
  // A firmware value write on a tick cycle swallows the terminal event.
  assign w_term    = w_tick & ~w_val_wr & w_at_term;
  assign w_w1c     = reg_cfg_we[0] & reg_cfg_di[CFG_PEND];

  always_comb begin
    w_value_nxt = r_value;
    if (w_val_wr) begin
      w_value_nxt = WIDTH'(bytewrite(REG_W'(r_value), REG_W'(reg_val_di), reg_val_we));
    end else if (w_tick && !w_at_term) begin
      w_value_nxt = r_up ? r_value + 1'b1 : r_value - 1'b1;
    end else if (w_term && !r_oneshot) begin
      w_value_nxt = r_up ? '0 : r_limit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en      <= 1'b0;
      r_oneshot <= 1'b0;
      r_up      <= 1'b0;
      r_irqen   <= 1'b0;
      r_pend    <= 1'b0;
      r_presc   <= '0;
      r_value   <= '0;
      r_limit   <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_value <= w_value_nxt;
      r_limit <= WIDTH'(bytewrite(REG_W'(r_limit), REG_W'(reg_dat_di), reg_dat_we));
      r_tick  <= w_term;
      r_pend  <= w_term | (r_pend & ~w_w1c);
      if (reg_cfg_we[0]) begin
        r_en      <= reg_cfg_di[CFG_EN];
        r_oneshot <= reg_cfg_di[CFG_ONESHOT];
        r_up      <= reg_cfg_di[CFG_UP];
        r_irqen   <= reg_cfg_di[CFG_IRQEN];
      end else if (w_term && r_oneshot) begin
        r_en <= 1'b0;
      end
      if (reg_cfg_we[1]) begin
        r_presc <= reg_cfg_di[CFG_PRESC_LSB +: PRESCALE_W];
      end
    end
  end

  always_comb begin
    reg_cfg_do                               = '0;
    reg_cfg_do[CFG_EN]                       = r_en;
    reg_cfg_do[CFG_ONESHOT]                  = r_oneshot;
    reg_cfg_do[CFG_UP]                       = r_up;
    reg_cfg_do[CFG_IRQEN]                    = r_irqen;
    reg_cfg_do[CFG_PEND]                     = r_pend;
    reg_cfg_do[CFG_PRESC_LSB +: PRESCALE_W]  = r_presc;
  end

  assign reg_val_do = r_value;
  assign reg_dat_do = r_limit;
  assign tick_out   = r_tick;
  assign irq_out    = r_pend & r_irqen;

endmodule
`default_nettype wire

// File: tb/tb_mgmt_counter_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mgmt_counter_timer : directed scenarios plus random register     |
// | traffic checked against a cycle-level behavioural model. Rev 1.0    |
// +--------------------------------------------------------------------+
module tb_mgmt_counter_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  reg_cfg_we, reg_val_we, reg_dat_we;
  logic [31:0] reg_cfg_di, reg_val_di, reg_dat_di;
  logic [31:0] reg_cfg_do, reg_val_do, reg_dat_do;
  logic        tick_out, irq_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mgmt_counter_timer #(.WIDTH(32), .PRESCALE_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .reg_cfg_we (reg_cfg_we),
    .reg_cfg_di (reg_cfg_di),
    .reg_cfg_do (reg_cfg_do),
    .reg_val_we (reg_val_we),
    .reg_val_di (reg_val_di),
    .reg_val_do (reg_val_do),
    .reg_dat_we (reg_dat_we),
    .reg_dat_di (reg_dat_di),
    .reg_dat_do (reg_dat_do),
    .tick_out   (tick_out),
    .irq_out    (irq_out)
  );

  // Reference model state: what the peripheral registers should hold now.
  bit          m_en, m_os, m_up, m_ie, m_pend, m_tick;
  logic [7:0]  m_presc, m_phase;
  logic [31:0] m_val, m_lim;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] nw,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_cfg();
    return {16'h0, m_presc, 2'b00, m_pend, 1'b0, m_ie, m_up, m_os, m_en};
  endfunction

  task automatic model_reset();
    m_en = 0; m_os = 0; m_up = 0; m_ie = 0; m_pend = 0; m_tick = 0;
    m_presc = 0; m_phase = 0; m_val = 0; m_lim = 0;
  endtask

  // One clock of peripheral behaviour, driven by the inputs present at the edge.
  task automatic model_step();
    bit          tk, term, en_n;
    logic [31:0] nv;
    tk   = m_en && (m_phase == m_presc);
    term = 0;
    nv   = m_val;
    if (reg_val_we != 4'h0) begin
      nv = merge(m_val, reg_val_di, reg_val_we);
    end else if (tk) begin
      if (m_up) begin
        if (m_val == m_lim) begin term = 1; nv = m_os ? m_lim : 32'h0; end
        else nv = m_val + 32'h1;
      end else begin
        if (m_val == 32'h0) begin term = 1; nv = m_os ? 32'h0 : m_lim; end
        else nv = m_val - 32'h1;
      end
    end
    en_n = m_en;
    if (term && m_os) en_n = 0;
    m_phase = (!m_en || tk) ? 8'h0 : m_phase + 8'h1;
    if (reg_cfg_we[0] && reg_cfg_di[5]) m_pend = 0;
    if (term) m_pend = 1;
    if (reg_cfg_we[0]) begin
      en_n = reg_cfg_di[0]; m_os = reg_cfg_di[1]; m_up = reg_cfg_di[2]; m_ie = reg_cfg_di[3];
    end
    if (reg_cfg_we[1]) m_presc = reg_cfg_di[15:8];
    m_en   = en_n;
    m_lim  = merge(m_lim, reg_dat_di, reg_dat_we);
    m_val  = nv;
    m_tick = term;
  endtask

  // Apply one cycle of bus inputs, check all outputs mid-cycle, advance the model.
  task automatic cyc(input logic [3:0] cwe, input logic [31:0] cdi,
                     input logic [3:0] vwe, input logic [31:0] vdi,
                     input logic [3:0] dwe, input logic [31:0] ddi);
    reg_cfg_we = cwe; reg_cfg_di = cdi;
    reg_val_we = vwe; reg_val_di = vdi;
    reg_dat_we = dwe; reg_dat_di = ddi;
    @(negedge clk);
    chk("cfg_do", reg_cfg_do, m_cfg());
    chk("val_do", reg_val_do, m_val);
    chk("dat_do", reg_dat_do, m_lim);
    chk("tick_out", {31'h0, tick_out}, {31'h0, m_tick});
    chk("irq_out", {31'h0, irq_out}, {31'h0, m_pend & m_ie});
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    cyc(4'h0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0);
  endtask

  logic [31:0] t1_exp [7] = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd5, 32'd4};
  int          n_ticks;
  bit          saw_irq;
  logic [31:0] prev, tgt, msk, cdi, vdi, ddi;
  logic [3:0]  cwe, vwe, dwe;

  initial begin
    reg_cfg_we = 0; reg_cfg_di = 0; reg_val_we = 0; reg_val_di = 0;
    reg_dat_we = 0; reg_dat_di = 0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_cfg", reg_cfg_do, 32'h0);
    chk("rst_val", reg_val_do, 32'h0);
    chk("rst_dat", reg_dat_do, 32'h0);
    chk("rst_irq", {31'h0, irq_out}, 32'h0);

    // Down, continuous with interrupt
    cyc(4'h0, 0, 4'h0, 0, 4'hF, 32'd5);
    cyc(4'h0, 0, 4'hF, 32'd5, 4'h0, 0);
    cyc(4'h1, 32'h09, 4'h0, 0, 4'h0, 0);
    for (int k = 0; k < 7; k++) begin
      idle();
      chk("t1_val", reg_val_do, t1_exp[k]);
      chk("t1_tick", {31'h0, tick_out}, (k == 5) ? 32'h1 : 32'h0);
      chk("t1_irq", {31'h0, irq_out}, (k >= 5) ? 32'h1 : 32'h0);
    end
    cyc(4'h1, 32'h20, 4'h0, 0, 4'h0, 0);
    chk("t1_irq_clr", {31'h0, irq_out}, 32'h0);

    // Up, oneshot
    cyc(4'h0, 0, 4'h0, 0, 4'hF, 32'd3);
    cyc(4'h0, 0, 4'hF, 32'd0, 4'h0, 0);
    cyc(4'h1, 32'h07, 4'h0, 0, 4'h0, 0);
    n_ticks = 0; saw_irq = 0;
    for (int k = 0; k < 7; k++) begin
      idle();
      if (tick_out) n_ticks++;
      if (irq_out) saw_irq = 1;
      if (k < 3) chk("t2_val", reg_val_do, k + 1);
    end
    chk("t2_hold", reg_val_do, 32'd3);
    chk("t2_cfg", reg_cfg_do, 32'h26);
    chk("t2_ticks", n_ticks, 32'd1);
    chk("t2_irq", {31'h0, saw_irq}, 32'h0);

    // Prescale 3
    cyc(4'h1, 32'h20, 4'h0, 0, 4'h0, 0);
    cyc(4'h0, 0, 4'hF, 32'h10, 4'h0, 0);
    cyc(4'h3, 32'h0301, 4'h0, 0, 4'h0, 0);
    for (int k = 1; k <= 16; k++) begin
      idle();
      if (k == 3)  chk("t3_hold3", reg_val_do, 32'h10);
      if (k == 4)  chk("t3_first", reg_val_do, 32'h0F);
    end
    chk("t3_val16", reg_val_do, 32'h0C);

    // Races: value write on terminal cycle, W1C on terminal cycle
    cyc(4'h3, 32'h20, 4'h0, 0, 4'h0, 0);
    cyc(4'h0, 0, 4'h0, 0, 4'hF, 32'd9);
    cyc(4'h0, 0, 4'hF, 32'd2, 4'h0, 0);
    cyc(4'h3, 32'h01, 4'h0, 0, 4'h0, 0);
    idle(); idle();
    chk("t4_at0", reg_val_do, 32'h0);
    cyc(4'h0, 0, 4'hF, 32'h100, 4'h0, 0);
    chk("t4_valwin", reg_val_do, 32'h100);
    chk("t4_nopend", reg_cfg_do, 32'h01);
    chk("t4_notick", {31'h0, tick_out}, 32'h0);
    cyc(4'h0, 0, 4'hF, 32'd1, 4'h0, 0);
    idle();
    cyc(4'h1, 32'h21, 4'h0, 0, 4'h0, 0);
    chk("t4_setwins", reg_cfg_do, 32'h21);
    chk("t4_reload", reg_val_do, 32'd9);

    // Byte lanes, long count, async reset
    cyc(4'h1, 32'h20, 4'h0, 0, 4'h0, 0);
    tgt = 32'hdcba9876;
    for (int b = 0; b < 4; b++) begin
      msk = 32'hFF << (8 * b);
      prev = $urandom;
      cyc(4'h0, 0, 4'(1 << b), (tgt & msk) | (prev & ~msk),
          4'(1 << b), (tgt & msk) | (~prev & ~msk));
    end
    chk("t5_lim", reg_dat_do, tgt);
    chk("t5_val", reg_val_do, tgt);
    cyc(4'h1, 32'h01, 4'h0, 0, 4'h0, 0);
    prev = reg_val_do;
    for (int k = 0; k < 5; k++) begin
      idle();
      chk("t5_below", {31'h0, reg_val_do < tgt}, 32'h1);
      chk("t5_dec", {31'h0, reg_val_do < prev}, 32'h1);
      prev = reg_val_do;
    end
    reset = 1'b1;
    #1;
    chk("t5_rst_cfg", reg_cfg_do, 32'h0);
    chk("t5_rst_val", reg_val_do, 32'h0);
    chk("t5_rst_dat", reg_dat_do, 32'h0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    idle();
    chk("t5_stays0", reg_val_do, 32'h0);

    // Random register traffic against the model
    for (int i = 0; i < 400; i++) begin
      cwe = 0; vwe = 0; dwe = 0;
      cdi = $urandom; vdi = $urandom; ddi = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        cwe = 4'($urandom);
        cdi[15:8] = 8'($urandom_range(0, 2));
        cdi[0] = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 11) == 0) begin
        vwe = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
        vdi = $urandom_range(0, 12);
      end
      if ($urandom_range(0, 11) == 0) begin
        dwe = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
        ddi = $urandom_range(0, 12);
      end
      cyc(cwe, cdi, vwe, vdi, dwe, ddi);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
